// File: rtl/intersection_pkg.sv
// Shared types and constants for the intersection phase sequencer:
// state encoding, signal-head light encodings and side indices.
package intersection_pkg;

    typedef enum logic [2:0] {
        HWY_GREEN  = 3'd0,
        HWY_YELLOW = 3'd1,
        CLEAR1     = 3'd2,
        SIDE_GRN   = 3'd3,
        SIDE_YEL   = 3'd4,
        CLEAR2     = 3'd5,
        WALK       = 3'd6
    } state_t;

    // Signal head encoding {red,yellow,green}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

endpackage

// File: rtl/phase_timer.sv
// Loadable tick-driven down-counter that times every intersection phase.
// Holds at zero until reloaded; expired marks the tick on which the phase ends.
module phase_timer #(
    parameter int               CNT_W     = 4,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count <= RESET_VAL;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - 1'b1;
    end

    assign zero    = (count == '0);
    assign expired = zero && tick;

endmodule

// File: rtl/intersection_sequencer.sv
// Highway / two-side-road intersection phase sequencer with round-robin side service.
// Optional pedestrian phase is built when PED_PHASE_EN is defined.
module intersection_sequencer
    import intersection_pkg::*;
#(
    parameter int HWY_MIN_GREEN = 8,
    parameter int SIDE_GREEN    = 4,
    parameter int YELLOW        = 2,
    parameter int ALL_RED       = 1,
    parameter int WALK_TIME     = 6,
    parameter int CNT_W         = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] side_req,
    input  logic       ped_req,
    output logic [2:0] highway,
    output logic [2:0] side_a,
    output logic [2:0] side_b,
    output logic       walk,
    output logic [1:0] grant,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] LD_HWY   = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_SIDE  = CNT_W'(SIDE_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_YEL   = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] LD_WALK  = CNT_W'(WALK_TIME - 1);

    state_t           cur_state, next_state;
    logic [1:0]       pend;
    logic             last;
    logic             pick;
    logic             ped_pending;
    logic             enter_side;
    logic             enter_walk;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_expired;
    logic             timer_zero_unused;

    phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (LD_HWY)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero_unused),
        .expired  (timer_expired)
    );

    // When both sides wait, serve the one not served last time.
    assign pick = (pend == 2'b11) ? ~last : (pend[0] ? SIDE_A : SIDE_B);

    // NOTE: every variable driven here gets a default first, so no latches are inferred.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            HWY_GREEN:  if (timer_expired && (|pend || ped_pending)) next_state = HWY_YELLOW;
            HWY_YELLOW: if (timer_expired) next_state = CLEAR1;
`ifdef PED_PHASE_EN
            CLEAR1:     if (timer_expired) next_state = (|pend) ? SIDE_GRN : WALK;
`else
            CLEAR1:     if (timer_expired) next_state = SIDE_GRN;
`endif
            SIDE_GRN:   if (timer_expired) next_state = SIDE_YEL;
            SIDE_YEL:   if (timer_expired) next_state = CLEAR2;
            CLEAR2:     if (timer_expired) next_state = ped_pending ? WALK : HWY_GREEN;
`ifdef PED_PHASE_EN
            WALK:       if (timer_expired) next_state = HWY_GREEN;
`endif
            default:    next_state = HWY_GREEN;
        endcase
    end

    always_comb begin
        timer_val = LD_HWY;
        case (next_state)
            HWY_YELLOW, SIDE_YEL: timer_val = LD_YEL;
            CLEAR1, CLEAR2:       timer_val = LD_CLEAR;
            SIDE_GRN:             timer_val = LD_SIDE;
            WALK:                 timer_val = LD_WALK;
            default:              timer_val = LD_HWY;
        endcase
    end

    assign timer_load = (next_state != cur_state);
    assign enter_side = (next_state == SIDE_GRN) && (cur_state != SIDE_GRN);
    assign enter_walk = (next_state == WALK) && (cur_state != WALK);

    // A clear on phase entry beats a same-cycle set; a still-high request re-sets it next clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_state <= HWY_GREEN;
            pend      <= 2'b00;
            last      <= SIDE_B;
        end else begin
            cur_state <= next_state;
            pend      <= (pend | side_req) & ~(enter_side ? (2'b01 << pick) : 2'b00);
            if (enter_side)
                last <= pick;
        end
    end

`ifdef PED_PHASE_EN
    logic ped_pend;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ped_pend <= 1'b0;
        else
            ped_pend <= enter_walk ? 1'b0 : (ped_pend | ped_req);
    end

    assign ped_pending = ped_pend;
`else
    logic unused_ped;
    logic unused_walk_entry;

    assign unused_ped        = ped_req;
    assign unused_walk_entry = enter_walk;
    assign ped_pending       = 1'b0;
`endif

    // Moore decode; during side phases `last` names the side being served.
    always_comb begin
        highway = RED;
        side_a  = RED;
        side_b  = RED;
        walk    = 1'b0;
        grant   = 2'b00;
        case (cur_state)
            HWY_GREEN:  highway = GRN;
            HWY_YELLOW: highway = YEL;
            SIDE_GRN, SIDE_YEL: begin
                grant = (last == SIDE_A) ? 2'b01 : 2'b10;
                if (last == SIDE_A)
                    side_a = (cur_state == SIDE_GRN) ? GRN : YEL;
                else
                    side_b = (cur_state == SIDE_GRN) ? GRN : YEL;
            end
`ifdef PED_PHASE_EN
            WALK:       walk = 1'b1;
`endif
            default: ;
        endcase
    end

    assign state = cur_state;

endmodule
